// File: rtl/safety_pkg.sv
// ============================================================================
// Module      : safety_pkg
// Description : Shared channel FSM state type, clear-register address and
//               midscale helper for the current safety monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package safety_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_TRIPPED = 2'd2
    } ch_state_t;

    localparam logic [7:0] CLR_ADDR  = 8'h0C;
    localparam int unsigned MAX_WIDTH = 32;

    // Offset-binary zero point for a sample of the given width.
    function automatic logic [MAX_WIDTH-1:0] midscale(input int unsigned width);
        return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/safety_channel.sv
// ============================================================================
// Module      : safety_channel
// Description : One monitored axis: magnitude compare, OK/SUSPECT/TRIPPED FSM
//               with saturating violation counter. Command-change holdoff is
//               built only when SAFETY_HOLDOFF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module safety_channel
    import safety_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TRIP_COUNT = 8,
    parameter int unsigned MARGIN     = 'h0200,
    parameter int unsigned HOLDOFF    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_fb,
    input  logic [WIDTH-1:0] i_cmd,
    input  logic             i_sample_valid,
    input  logic             i_clear,
    output logic             o_tripped,
    output logic             o_suspect,
    output logic             o_trip_now
);

    localparam int unsigned      c_CW   = WIDTH + 2;
    localparam logic [WIDTH-1:0] c_MID  = WIDTH'(midscale(WIDTH));
    localparam logic [7:0]       c_TRIP = 8'(TRIP_COUNT);

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (x - c_MID) : (c_MID - x);
    endfunction

    ch_state_t       r_state;
    ch_state_t       w_state_next;
    ch_state_t       w_eval_state;
    logic [7:0]      r_cnt;
    logic [7:0]      w_cnt_next;
    logic [7:0]      w_eval_cnt;
    logic [8:0]      w_cnt_inc;
    logic [WIDTH-1:0] w_fb_mag;
    logic [WIDTH-1:0] w_cmd_mag;
    logic [c_CW-1:0] w_limit;
    logic            w_viol;
    logic            w_blank;
    logic            w_eval;
    logic            w_trip_hit;

    assign w_fb_mag  = mag(i_fb);
    assign w_cmd_mag = mag(i_cmd);
    // Limit is 2*|cmd| + MARGIN; two extra bits keep the sum from wrapping.
    assign w_limit   = {1'b0, w_cmd_mag, 1'b0} + c_CW'(MARGIN);
    assign w_viol    = {2'b00, w_fb_mag} > w_limit;
    assign w_eval    = i_sample_valid && !w_blank;
    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

`ifdef SAFETY_HOLDOFF_EN
    localparam logic [7:0] c_HOLDOFF = 8'(HOLDOFF);

    logic [WIDTH-1:0] r_cmd;
    logic [7:0]       r_hold;
    logic             w_cmd_change;

    assign w_cmd_change = (i_cmd != r_cmd);

    // A strobe coinciding with the change is itself blanked and consumes one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cmd  <= c_MID;
            r_hold <= '0;
        end else begin
            r_cmd <= i_cmd;
            if (w_cmd_change) begin
                r_hold <= (i_sample_valid && c_HOLDOFF != 8'd0) ? c_HOLDOFF - 8'd1 : c_HOLDOFF;
            end else if (i_sample_valid && r_hold != 8'd0) begin
                r_hold <= r_hold - 8'd1;
            end
        end
    end

    assign w_blank = (c_HOLDOFF != 8'd0) && (w_cmd_change || r_hold != 8'd0);
`else
    localparam int unsigned c_unused_holdoff = HOLDOFF;
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_OK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_eval_state = r_state;
        w_eval_cnt   = r_cnt;
        case (r_state)
            ST_OK: begin
                if (w_eval && w_viol) begin
                    w_eval_cnt   = 8'd1;
                    w_eval_state = (c_TRIP <= 8'd1) ? ST_TRIPPED : ST_SUSPECT;
                end
            end
            ST_SUSPECT: begin
                if (w_eval) begin
                    if (!w_viol) begin
                        w_eval_state = ST_OK;
                        w_eval_cnt   = 8'd0;
                    end else if (w_cnt_inc >= {1'b0, c_TRIP}) begin
                        w_eval_state = ST_TRIPPED;
                        w_eval_cnt   = c_TRIP;
                    end else begin
                        w_eval_cnt   = w_cnt_inc[7:0];
                    end
                end
            end
            default: begin
                w_eval_state = ST_TRIPPED;
            end
        endcase

        // A trip completing this cycle outranks a coincident clear.
        w_trip_hit   = (r_state != ST_TRIPPED) && (w_eval_state == ST_TRIPPED);
        w_state_next = w_eval_state;
        w_cnt_next   = w_eval_cnt;
        if (i_clear && !w_trip_hit) begin
            w_state_next = ST_OK;
            w_cnt_next   = 8'd0;
        end
    end

    always_comb begin
        o_tripped  = (r_state == ST_TRIPPED);
        o_suspect  = (r_state == ST_SUSPECT);
        o_trip_now = w_trip_hit;
    end

endmodule

`default_nettype wire

// File: rtl/current_safety_monitor.sv
// ============================================================================
// Module      : current_safety_monitor
// Description : Per-axis overcurrent monitor with latched amplifier disable,
//               register clear and first-trip capture. Optional feature macro:
//               SAFETY_HOLDOFF_EN (blank evaluation after command changes).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module current_safety_monitor
    import safety_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned TRIP_COUNT = 8,
    parameter int unsigned MARGIN     = 'h0200,
    parameter int unsigned HOLDOFF    = 4
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] cur_fb,
    input  logic [NUM_CH*WIDTH-1:0] cur_cmd,
    input  logic                    sample_valid,
    input  logic                    reg_wen,
    input  logic [7:0]              reg_addr,
    input  logic [31:0]             reg_wdata,
    output logic [NUM_CH-1:0]       amp_disable,
    output logic [31:0]             fault_status
);

    logic [NUM_CH-1:0] w_tripped;
    logic [NUM_CH-1:0] w_suspect;
    logic [NUM_CH-1:0] w_trip_now;
    logic              w_clr_hit;
    logic [7:0]        w_first_ch;
    logic [7:0]        r_first_ch;
    logic              w_unused_wdata;

    assign w_clr_hit      = reg_wen && (reg_addr == CLR_ADDR);
    assign w_unused_wdata = ^reg_wdata;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            safety_channel #(
                .WIDTH      (WIDTH),
                .TRIP_COUNT (TRIP_COUNT),
                .MARGIN     (MARGIN),
                .HOLDOFF    (HOLDOFF)
            ) u_ch (
                .i_clk          (sysclk),
                .i_rst          (reset),
                .i_fb           (cur_fb[g*WIDTH +: WIDTH]),
                .i_cmd          (cur_cmd[g*WIDTH +: WIDTH]),
                .i_sample_valid (sample_valid),
                .i_clear        (w_clr_hit && reg_wdata[g]),
                .o_tripped      (w_tripped[g]),
                .o_suspect      (w_suspect[g]),
                .o_trip_now     (w_trip_now[g])
            );
        end
    endgenerate

    // Lowest-numbered channel among those tripping this cycle.
    always_comb begin
        w_first_ch = 8'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_trip_now[i]) begin
                w_first_ch = 8'(i);
            end
        end
    end

    // Captured only when nothing is already tripped; kept as history after clears.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_first_ch <= 8'd0;
        end else if ((w_tripped == '0) && (|w_trip_now)) begin
            r_first_ch <= w_first_ch;
        end
    end

    assign amp_disable  = w_tripped;
    assign fault_status = {|w_tripped, 7'd0, r_first_ch, 8'(w_suspect), 8'(w_tripped)};

endmodule

`default_nettype wire

// File: tb/tb_current_safety_monitor.sv
// ============================================================================
// Module      : tb_current_safety_monitor
// Description : Directed vector table plus hand sequences for the current
//               safety monitor (default 4 channels x 16 bits, trip count 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_current_safety_monitor;

    localparam logic [15:0] MID = 16'h8000;

    typedef struct {
        logic [63:0] fb;
        logic [63:0] cmd;
        logic        sv;
        logic        wen;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  exp_amp;
        logic [31:0] exp_st;
    } vec_t;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [63:0] cur_fb;
    logic [63:0] cur_cmd;
    logic        sample_valid;
    logic        reg_wen;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  amp_disable;
    logic [31:0] fault_status;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t q[$];

    current_safety_monitor dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .cur_fb       (cur_fb),
        .cur_cmd      (cur_cmd),
        .sample_valid (sample_valid),
        .reg_wen      (reg_wen),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .amp_disable  (amp_disable),
        .fault_status (fault_status)
    );

    always #5 sysclk = ~sysclk;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1);
    end

    function automatic logic [63:0] p4(input logic [15:0] c3, c2, c1, c0);
        return {c3, c2, c1, c0};
    endfunction

    function void add(input logic [63:0] fb, cmd, input logic sv, wen,
                      input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] amp, input logic [31:0] st, input int n);
        vec_t v;
        v.fb = fb; v.cmd = cmd; v.sv = sv; v.wen = wen; v.addr = addr;
        v.wdata = wdata; v.exp_amp = amp; v.exp_st = st;
        for (int k = 0; k < n; k++) q.push_back(v);
    endfunction

    function void add_s(input logic [63:0] fb, cmd, input logic [3:0] amp,
                        input logic [31:0] st, input int n);
        add(fb, cmd, 1'b1, 1'b0, 8'h00, 32'h0, amp, st, n);
    endfunction

    function void add_w(input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] amp, input logic [31:0] st);
        add(p4(MID, MID, MID, MID), p4(MID, MID, MID, MID), 1'b0, 1'b1, addr, wdata, amp, st, 1);
    endfunction

    task automatic check(input string name, input logic [3:0] e_amp, input logic [31:0] e_st);
        n_vec++;
        if (amp_disable !== e_amp || fault_status !== e_st) begin
            n_err++;
            $display("FAIL %s: amp_disable=%h fault_status=%h, expected amp_disable=%h fault_status=%h",
                     name, amp_disable, fault_status, e_amp, e_st);
        end
    endtask

    task automatic drive(input logic [63:0] fb, cmd, input logic sv);
        cur_fb = fb; cur_cmd = cmd; sample_valid = sv;
        reg_wen = 1'b0; reg_addr = 8'h00; reg_wdata = 32'h0;
    endtask

    task automatic step_check(input string name, input logic [3:0] e_amp, input logic [31:0] e_st);
        @(posedge sysclk);
        #1;
        check(name, e_amp, e_st);
    endtask

    logic [63:0] v0_fb, v0_cmd, v2_fb, v2_cmd, v13_fb, v13_cmd, v013_fb, v013_cmd;

    initial begin : main
        v0_fb    = p4(MID, MID, MID, 16'hC000);
        v0_cmd   = p4(MID, MID, MID, 16'h8100);
        v2_fb    = p4(MID, 16'hC000, MID, MID);
        v2_cmd   = p4(MID, 16'h8100, MID, MID);
        v13_fb   = p4(16'hC000, MID, 16'hC000, MID);
        v13_cmd  = p4(16'h8100, MID, 16'h8100, MID);
        v013_fb  = p4(16'hC000, MID, 16'hC000, 16'hC000);
        v013_cmd = p4(16'h8100, MID, 16'h8100, 16'h8100);

        // fb exactly twice cmd: never a violation
        add_s(p4(MID, MID, MID, 16'hA000), p4(MID, MID, MID, 16'h9000), 4'h0, 32'h0, 20);
        // threshold boundaries on both sides of midscale
        add_s(p4(MID, MID, MID, 16'hA200), p4(MID, MID, MID, 16'h9000), 4'h0, 32'h0, 1);
        add_s(p4(MID, MID, MID, 16'hA201), p4(MID, MID, MID, 16'h9000), 4'h0, 32'h0000_0100, 1);
        add_s(p4(MID, MID, MID, MID),      p4(MID, MID, MID, 16'h9000), 4'h0, 32'h0, 1);
        add_s(p4(MID, MID, MID, 16'h5DFF), p4(MID, MID, MID, 16'h7000), 4'h0, 32'h0000_0100, 1);
        add_s(p4(MID, MID, MID, 16'h5E00), p4(MID, MID, MID, 16'h7000), 4'h0, 32'h0, 1);
        // full-scale command: limit must not wrap
        add_s(p4(MID, MID, MID, 16'h0000), p4(MID, MID, MID, 16'h0000), 4'h0, 32'h0, 3);
        // seven violations then a clean sample
        add_s(v0_fb, v0_cmd, 4'h0, 32'h0000_0100, 7);
        add_s(p4(MID, MID, MID, MID), v0_cmd, 4'h0, 32'h0, 1);
        // eight violations with idle cycles between strobes
        for (int k = 0; k < 7; k++) begin
            add_s(v0_fb, v0_cmd, 4'h0, 32'h0000_0100, 1);
            add(v0_fb, v0_cmd, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 32'h0000_0100, 1);
        end
        add_s(v0_fb, v0_cmd, 4'h1, 32'h8000_0001, 1);
        add_s(p4(MID, MID, MID, MID), p4(MID, MID, MID, MID), 4'h1, 32'h8000_0001, 2);
        add_w(8'h08, 32'hF, 4'h1, 32'h8000_0001);
        add_w(8'h0D, 32'hF, 4'h1, 32'h8000_0001);
        add_w(8'h0C, 32'h1, 4'h0, 32'h0);
        // channel 2 trip, partial clear, then full clear
        add_s(v2_fb, v2_cmd, 4'h0, 32'h0000_0400, 7);
        add_s(v2_fb, v2_cmd, 4'h4, 32'h8002_0004, 1);
        add_w(8'h0C, 32'hB, 4'h4, 32'h8002_0004);
        add_w(8'h0C, 32'h4, 4'h0, 32'h0002_0000);
        // clear coinciding with the trip-completing sample
        add_s(v2_fb, v2_cmd, 4'h0, 32'h0002_0400, 7);
        add(v2_fb, v2_cmd, 1'b1, 1'b1, 8'h0C, 32'h4, 4'h4, 32'h8002_0004, 1);
        add_w(8'h0C, 32'h4, 4'h0, 32'h0002_0000);
        // simultaneous ch1/ch3 trip, then a later ch0 trip
        add_s(v13_fb, v13_cmd, 4'h0, 32'h0002_0A00, 7);
        add_s(v13_fb, v13_cmd, 4'hA, 32'h8001_000A, 1);
        add_s(v013_fb, v013_cmd, 4'hA, 32'h8001_010A, 7);
        add_s(v013_fb, v013_cmd, 4'hB, 32'h8001_000B, 1);
        add_w(8'h0C, 32'hF, 4'h0, 32'h0001_0000);

        drive(v0_fb, v0_cmd, 1'b1);
        @(posedge sysclk);
        #1;
        check("reset_state", 4'h0, 32'h0);
        drive(p4(MID, MID, MID, MID), p4(MID, MID, MID, MID), 1'b0);
        @(negedge sysclk);
        reset = 1'b0;

`ifdef SAFETY_HOLDOFF_EN
        drive(p4(MID, MID, MID, MID), p4(MID, MID, MID, MID), 1'b1);
        step_check("hold_idle0", 4'h0, 32'h0);
        step_check("hold_idle1", 4'h0, 32'h0);
        drive(v0_fb, v0_cmd, 1'b0);
        step_check("hold_step", 4'h0, 32'h0);
        drive(v0_fb, v0_cmd, 1'b1);
        for (int k = 1; k <= 4; k++) step_check($sformatf("hold_blank%0d", k), 4'h0, 32'h0);
        for (int k = 1; k <= 7; k++) step_check($sformatf("hold_count%0d", k), 4'h0, 32'h0000_0100);
        step_check("hold_trip", 4'h1, 32'h8000_0001);
`else
        foreach (q[i]) begin
            cur_fb = q[i].fb; cur_cmd = q[i].cmd; sample_valid = q[i].sv;
            reg_wen = q[i].wen; reg_addr = q[i].addr; reg_wdata = q[i].wdata;
            step_check($sformatf("vec%0d", i), q[i].exp_amp, q[i].exp_st);
        end

        // reset in the middle of a suspect count
        drive(v0_fb, v0_cmd, 1'b1);
        repeat (4) @(posedge sysclk);
        step_check("mid_suspect5", 4'h0, 32'h0001_0100);
        #2 reset = 1'b1;
        #1 check("async_reset", 4'h0, 32'h0);
        sample_valid = 1'b0;
        @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        sample_valid = 1'b1;
        for (int k = 1; k <= 7; k++) step_check($sformatf("recount%0d", k), 4'h0, 32'h0000_0100);
        step_check("recount_trip", 4'h1, 32'h8000_0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
